// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: sequential instruction fetch with credit-limited prefetch queue and redirect flush
module ifetch_prefetch #(
  parameter int PC_W = 64,
  parameter int DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [PC_W-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [PC_W-1:0] dec_pc,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_nxt;
  logic [PC_W-1:0] fetch_pc, rsp_pc, redir_pc;
  logic [CW-1:0] count, outstanding, drop_cnt;
  logic [CW-1:0] count_nxt, outstanding_nxt, drop_nxt;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [31:0] instr_q [DEPTH];
  logic [PC_W-1:0] pc_q [DEPTH];
  logic [CW:0] credit;
  logic req_fire, push, pop;
  assign redir_pc = redirect_pc & ~PC_W'(3);
  assign credit = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = reset_n && !redirect_valid && (credit < (CW+1)'(DEPTH));
  assign imem_req_addr = fetch_pc;
  assign dec_valid = count != '0;
  assign dec_instr = dec_valid ? instr_q[rd_ptr] : NOP_INSTR;
  assign dec_pc = dec_valid ? pc_q[rd_ptr] : '0;
  // Handshakes, counter updates and flush state; redirect overrides every other event
  always_comb begin
    req_fire = imem_req_valid && imem_req_ready;
    push = imem_rsp_valid && !redirect_valid && state == RUN;
    pop = dec_valid && dec_ready && !redirect_valid;
    outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_nxt = redirect_valid ? outstanding - CW'(imem_rsp_valid)
                              : drop_cnt - CW'(imem_rsp_valid && state == FLUSH);
    count_nxt = redirect_valid ? '0 : count + CW'(push) - CW'(pop);
    state_nxt = (drop_nxt != '0) ? FLUSH : RUN;
  end
  // Flush state register: FLUSH while stale responses remain to be dropped
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= RUN;
    else state <= state_nxt;
  end
  // PCs, counters and queue pointers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      count <= '0;
      outstanding <= '0;
      drop_cnt <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      drop_cnt <= drop_nxt;
      count <= count_nxt;
      if (redirect_valid) begin
        fetch_pc <= redir_pc;
        rsp_pc <= redir_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + PC_W'(4);
        if (push) rsp_pc <= rsp_pc + PC_W'(4);
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
  // Queue storage; contents are only meaningful below count so no reset is needed
  always_ff @(posedge clock) begin
    if (push) instr_q[wr_ptr] <= imem_rsp_data;
    if (push) pc_q[wr_ptr] <= rsp_pc;
  end
  // A response with nothing outstanding would underflow both outstanding and drop_cnt
  assert property (@(posedge clock) disable iff (!reset_n) imem_rsp_valid |-> outstanding != '0);
endmodule
